// File: rtl/mem_resp.sv
// mem_resp: MEM-stage response half; issues the SRAM-like data access, aligns and merges load data, hands off to WB.
module mem_resp (
  input  logic        clk,
  input  logic        resetn,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_allowin,
  input  logic        in_res_from_mem,
  input  logic        in_res_to_mem,
  input  logic [6:0]  in_load_op,
  input  logic [1:0]  in_addr_lo,
  input  logic        in_mem_ex,
  input  logic        in_data_wr,
  input  logic [1:0]  in_data_size,
  input  logic [3:0]  in_data_wstrb,
  input  logic [31:0] in_data_addr,
  input  logic [31:0] in_data_wdata,
  input  logic [31:0] in_rt_old,
  input  logic [31:0] in_result,
  input  logic [4:0]  in_dest,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [3:0]  data_wstrb,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata,
  output logic        out_valid,
  input  logic        out_allowin,
  output logic [31:0] out_result,
  output logic [4:0]  out_dest,
  output logic        out_ex
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;
  localparam logic [1:0] DONE = 2'd3;
  logic [1:0]  state_q, state_d;
  logic        cancel_q, cancel_d;
  logic        is_load_q;
  logic        mem_ex_q;
  logic [6:0]  load_op_q;
  logic [1:0]  addr_lo_q;
  logic [31:0] rt_q;
  logic [31:0] result_q;
  logic [4:0]  dest_q;
  logic        data_req_q;
  logic        data_wr_q;
  logic [1:0]  data_size_q;
  logic [3:0]  data_wstrb_q;
  logic [31:0] data_addr_q;
  logic [31:0] data_wdata_q;
  logic [31:0] out_result_q;
  logic        idle, done, busy, capture, mem_go, addr_hs, resp;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [31:0] lwl_v, lwr_v, load_v;
  assign idle    = state_q == IDLE;
  assign done    = state_q == DONE;
  assign busy    = (state_q == REQ) | (state_q == WAIT);
  assign in_allowin = idle | (done & (out_allowin | cancel_q));
  assign capture = in_valid & in_allowin & ~flush;
  assign mem_go  = (in_res_from_mem | in_res_to_mem) & ~in_mem_ex;
  assign addr_hs = (state_q == REQ) & data_addr_ok;
  assign resp    = (state_q == WAIT) & data_data_ok;
  always_comb begin
    state_d = capture                                    ? (mem_go ? REQ : DONE) :
              done & (flush | out_allowin | cancel_q)    ? IDLE :
              addr_hs                                    ? WAIT :
              resp                                       ? ((cancel_q | flush) ? IDLE : DONE) :
                                                           state_q;
    cancel_d = state_d == IDLE   ? 1'b0 :
               busy & flush      ? 1'b1 :
                                   cancel_q;
  end
  // little-endian byte/half select, then lwl/lwr merge with the old rt value
  always_comb begin
    byte_v = addr_lo_q[1] ? (addr_lo_q[0] ? data_rdata[31:24] : data_rdata[23:16])
                          : (addr_lo_q[0] ? data_rdata[15:8]  : data_rdata[7:0]);
    half_v = addr_lo_q[1] ? data_rdata[31:16] : data_rdata[15:0];
    lwl_v  = addr_lo_q == 2'd0 ? {data_rdata[7:0],  rt_q[23:0]} :
             addr_lo_q == 2'd1 ? {data_rdata[15:0], rt_q[15:0]} :
             addr_lo_q == 2'd2 ? {data_rdata[23:0], rt_q[7:0]}  :
                                 data_rdata;
    lwr_v  = addr_lo_q == 2'd0 ? data_rdata :
             addr_lo_q == 2'd1 ? {rt_q[31:24], data_rdata[31:8]}  :
             addr_lo_q == 2'd2 ? {rt_q[31:16], data_rdata[31:16]} :
                                 {rt_q[31:8],  data_rdata[31:24]};
    load_v = load_op_q[0] ? {{24{byte_v[7]}}, byte_v} :
             load_op_q[1] ? {24'd0, byte_v} :
             load_op_q[2] ? {{16{half_v[15]}}, half_v} :
             load_op_q[3] ? {16'd0, half_v} :
             load_op_q[5] ? lwl_v :
             load_op_q[6] ? lwr_v :
                            data_rdata;
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      cancel_q     <= 1'b0;
      is_load_q    <= 1'b0;
      mem_ex_q     <= 1'b0;
      load_op_q    <= '0;
      addr_lo_q    <= '0;
      rt_q         <= '0;
      result_q     <= '0;
      dest_q       <= '0;
      data_req_q   <= 1'b0;
      data_wr_q    <= 1'b0;
      data_size_q  <= '0;
      data_wstrb_q <= '0;
      data_addr_q  <= '0;
      data_wdata_q <= '0;
      out_result_q <= '0;
    end else begin
      state_q  <= state_d;
      cancel_q <= cancel_d;
      if (capture) begin
        is_load_q <= in_res_from_mem;
        mem_ex_q  <= in_mem_ex;
        load_op_q <= in_load_op;
        addr_lo_q <= in_addr_lo;
        rt_q      <= in_rt_old;
        result_q  <= in_result;
        dest_q    <= in_dest;
        if (!mem_go) out_result_q <= in_result;
      end
      if (capture && mem_go) begin
        data_wr_q    <= in_data_wr;
        data_size_q  <= in_data_size;
        data_wstrb_q <= in_data_wstrb;
        data_addr_q  <= in_data_addr;
        data_wdata_q <= in_data_wdata;
      end
      data_req_q <= (capture & mem_go) | (data_req_q & ~addr_hs);
      if (resp && !cancel_q && !flush) out_result_q <= is_load_q ? load_v : result_q;
    end
  end
  assign data_req   = data_req_q;
  assign data_wr    = data_wr_q;
  assign data_size  = data_size_q;
  assign data_wstrb = data_wstrb_q;
  assign data_addr  = data_addr_q;
  assign data_wdata = data_wdata_q;
  assign out_valid  = done & ~cancel_q;
  assign out_result = out_result_q;
  assign out_dest   = dest_q;
  assign out_ex     = mem_ex_q;
endmodule

// File: tb/tb_mem_resp.sv
// tb_mem_resp: directed stimulus with a queue scoreboard and a latency-programmable SRAM-like bus responder.
module tb_mem_resp;
  logic        clk, resetn, flush, in_valid, in_allowin;
  logic        in_res_from_mem, in_res_to_mem, in_mem_ex, in_data_wr;
  logic [6:0]  in_load_op;
  logic [1:0]  in_addr_lo, in_data_size;
  logic [3:0]  in_data_wstrb;
  logic [31:0] in_data_addr, in_data_wdata, in_rt_old, in_result;
  logic [4:0]  in_dest;
  logic        data_req, data_wr, data_addr_ok, data_data_ok;
  logic [1:0]  data_size;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic        out_valid, out_allowin, out_ex;
  logic [31:0] out_result;
  logic [4:0]  out_dest;

  typedef struct packed {logic [31:0] res; logic [4:0] dest; logic ex;} exp_t;
  exp_t q[$];
  int tests = 0, fails = 0, req_cnt = 0;
  int addr_dly = 0, data_dly = 0;
  logic [31:0] bus_rdata = 0, cur_addr = 0;

  localparam logic [6:0] LB = 7'b0000001, LBU = 7'b0000010, LH = 7'b0000100, LHU = 7'b0001000;
  localparam logic [6:0] LW = 7'b0010000, LWL = 7'b0100000, LWR = 7'b1000000;

  mem_resp dut (
    .clk(clk), .resetn(resetn), .flush(flush), .in_valid(in_valid), .in_allowin(in_allowin),
    .in_res_from_mem(in_res_from_mem), .in_res_to_mem(in_res_to_mem), .in_load_op(in_load_op),
    .in_addr_lo(in_addr_lo), .in_mem_ex(in_mem_ex), .in_data_wr(in_data_wr), .in_data_size(in_data_size),
    .in_data_wstrb(in_data_wstrb), .in_data_addr(in_data_addr), .in_data_wdata(in_data_wdata),
    .in_rt_old(in_rt_old), .in_result(in_result), .in_dest(in_dest),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .out_valid(out_valid), .out_allowin(out_allowin), .out_result(out_result),
    .out_dest(out_dest), .out_ex(out_ex)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // bus responder: addr_ok after addr_dly cycles of data_req, data_ok data_dly cycles after that
  initial begin
    int phase = 0, cnt = 0;
    data_addr_ok = 0; data_data_ok = 0; data_rdata = 0;
    forever begin
      @(posedge clk); #1;
      data_addr_ok = 0; data_data_ok = 0;
      if (!resetn) phase = 0;
      else begin
        if (phase == 0 && data_req) begin phase = 1; cnt = addr_dly; end
        if (phase == 1) begin
          if (cnt == 0) begin data_addr_ok = 1; phase = 2; cnt = data_dly; end else cnt--;
        end else if (phase == 2) begin
          if (cnt == 0) begin data_data_ok = 1; data_rdata = bus_rdata; phase = 0; end else cnt--;
        end
      end
    end
  end

  // monitor: every presented output is checked against the scoreboard head; popped on handshake
  initial begin
    forever begin
      @(negedge clk);
      if (resetn) begin
        if (data_req) begin
          req_cnt++;
          chk("req_addr_stable", data_addr, cur_addr);
        end
        if (out_valid) begin
          if (q.size() == 0) chk("unexpected_out_valid", 32'(out_valid), 32'd0);
          else begin
            chk("out_result", out_result, q[0].res);
            chk("out_dest", 32'(out_dest), 32'(q[0].dest));
            chk("out_ex", 32'(out_ex), 32'(q[0].ex));
            if (out_allowin) void'(q.pop_front());
          end
        end
      end
    end
  end

  task automatic issue(input logic ld, input logic st, input logic [6:0] op, input logic [1:0] lo,
                       input logic ex, input logic [31:0] rt, input logic [31:0] res,
                       input logic [4:0] dest, input logic [31:0] exp, input logic push);
    logic ok;
    int n;
    if (push) q.push_back('{res: exp, dest: dest, ex: ex});
    cur_addr = {20'h00001, 5'd0, dest, lo};
    in_valid = 1; in_res_from_mem = ld; in_res_to_mem = st; in_load_op = op; in_addr_lo = lo;
    in_mem_ex = ex; in_data_wr = st; in_data_size = 2'd2; in_data_wstrb = st ? 4'hf : 4'h0;
    in_data_addr = cur_addr; in_data_wdata = res; in_rt_old = rt; in_result = res; in_dest = dest;
    n = 0;
    do begin
      @(negedge clk); ok = in_allowin; n++;
      @(posedge clk); #1;
    end while (!ok && n < 100);
    if (!ok) chk("issue_timeout", 32'(ok), 32'd1);
    in_valid = 0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((q.size() != 0 || out_valid) && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) chk("drain_timeout", 32'(q.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    int n;
    resetn = 0; flush = 0; in_valid = 0; in_res_from_mem = 0; in_res_to_mem = 0; in_load_op = 0;
    in_addr_lo = 0; in_mem_ex = 0; in_data_wr = 0; in_data_size = 0; in_data_wstrb = 0;
    in_data_addr = 0; in_data_wdata = 0; in_rt_old = 0; in_result = 0; in_dest = 0; out_allowin = 1;
    repeat (2) @(negedge clk);
    chk("rst_data_req", 32'(data_req), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_allowin", 32'(in_allowin), 32'd1);
    chk("rst_data_addr", data_addr, 32'd0);
    chk("rst_out_result", out_result, 32'd0);
    @(posedge clk); #1; resetn = 1;

    // ALU op: out_valid one cycle after capture, no bus access
    req_cnt = 0;
    issue(0, 0, 7'd0, 2'd0, 0, 32'd0, 32'h1234_5678, 5'd3, 32'h1234_5678, 1);
    @(negedge clk); chk("alu_latency", 32'(out_valid), 32'd1);
    wait_idle();
    chk("alu_no_req", 32'(req_cnt), 32'd0);

    // lb with slow bus: data_req held exactly until addr_ok
    req_cnt = 0; addr_dly = 2; data_dly = 3; bus_rdata = 32'h80AA_BBCC;
    issue(1, 0, LB, 2'd3, 0, 32'd0, 32'd0, 5'd4, 32'hFFFF_FF80, 1);
    wait_idle();
    chk("lb_req_cycles", 32'(req_cnt), 32'd3);

    addr_dly = 0; data_dly = 0;
    issue(1, 0, LHU, 2'd2, 0, 32'd0, 32'd0, 5'd5, 32'h0000_80AA, 1); wait_idle();
    issue(1, 0, LH,  2'd0, 0, 32'd0, 32'd0, 5'd6, 32'hFFFF_BBCC, 1); wait_idle();
    issue(1, 0, LBU, 2'd1, 0, 32'd0, 32'd0, 5'd7, 32'h0000_00BB, 1); wait_idle();
    bus_rdata = 32'hAABB_CCDD;
    issue(1, 0, LWL, 2'd1, 0, 32'h1122_3344, 32'd0, 5'd8, 32'hCCDD_3344, 1); wait_idle();
    issue(1, 0, LWR, 2'd2, 0, 32'h1122_3344, 32'd0, 5'd9, 32'h1122_AABB, 1); wait_idle();
    issue(1, 0, LWL, 2'd3, 0, 32'h1122_3344, 32'd0, 5'd10, 32'hAABB_CCDD, 1); wait_idle();
    issue(1, 0, LWR, 2'd3, 0, 32'h1122_3344, 32'd0, 5'd11, 32'h1122_33AA, 1); wait_idle();
    issue(0, 1, 7'd0, 2'd0, 0, 32'd0, 32'hDEAD_0000, 5'd12, 32'hDEAD_0000, 1); wait_idle();

    // sw with address exception: no bus access, out_ex after 1 cycle
    req_cnt = 0;
    issue(0, 1, 7'd0, 2'd0, 1, 32'd0, 32'h0000_0055, 5'd13, 32'h0000_0055, 1);
    @(negedge clk); chk("ex_latency", 32'(out_valid), 32'd1); chk("ex_flag", 32'(out_ex), 32'd1);
    wait_idle();
    chk("ex_no_req", 32'(req_cnt), 32'd0);

    // flush in IDLE wins over capture
    in_valid = 1; in_res_from_mem = 1; in_load_op = LW; in_mem_ex = 0; flush = 1;
    @(posedge clk); #1; in_valid = 0; flush = 0;
    @(negedge clk);
    chk("flush_idle_valid", 32'(out_valid), 32'd0);
    chk("flush_idle_req", 32'(data_req), 32'd0);
    @(posedge clk); #1;

    // flush while waiting for data: response discarded
    data_dly = 2; bus_rdata = 32'h7777_7777;
    issue(1, 0, LW, 2'd0, 0, 32'd0, 32'd0, 5'd14, 32'd0, 0);
    n = 0;
    while (!(data_req && data_addr_ok) && n < 50) begin @(negedge clk); n++; end
    @(posedge clk); #1; flush = 1;
    @(posedge clk); #1; flush = 0;
    n = 0;
    do begin @(negedge clk); n++; end while (!data_data_ok && n < 50);
    chk("flush_dataok_seen", 32'(data_data_ok), 32'd1);
    chk("flush_busy_allowin", 32'(in_allowin), 32'd0);
    chk("flush_no_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("flush_allowin_back", 32'(in_allowin), 32'd1);
    chk("flush_no_valid2", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    data_dly = 0; bus_rdata = 32'h0102_0304;
    issue(1, 0, LW, 2'd0, 0, 32'd0, 32'd0, 5'd15, 32'h0102_0304, 1); wait_idle();

    // back-to-back loads under a 4-cycle WB stall
    out_allowin = 0; bus_rdata = 32'hCAFE_F00D;
    issue(1, 0, LW, 2'd0, 0, 32'd0, 32'd0, 5'd16, 32'hCAFE_F00D, 1);
    n = 0;
    do begin @(negedge clk); n++; end while (!out_valid && n < 50);
    chk("stall_valid", 32'(out_valid), 32'd1);
    bus_rdata = 32'h0BAD_BEEF;
    fork
      issue(1, 0, LHU, 2'd0, 0, 32'd0, 32'd0, 5'd17, 32'h0000_BEEF, 1);
      begin
        repeat (4) @(negedge clk);
        @(posedge clk); #1; out_allowin = 1;
        @(negedge clk); chk("b2b_allowin", 32'(in_allowin), 32'd1);
        @(negedge clk); chk("b2b_captured", 32'(data_req), 32'd1);
      end
    join
    wait_idle();
    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mem_resp.md
Name: mem_resp

Overview:
- Second half of the MEM stage; sits directly downstream of the data-request generator.
- Takes one instruction at a time from the MEM pipeline register, together with the sized/strobed/aligned request fields that the generator already computed.
- Drives them onto the SRAM-like data interface with a req/addr_ok/data_ok handshake, waits for the load response, and aligns/extends/merges the returned word.
- Presents the final write-back payload to WB through a valid/allowin handshake, and cancels in-flight accesses on pipeline flush.

Parameters:
- none (widths fixed by the 32-bit ISA).

Ports:
- clk  input  1  core clock
- resetn  input  1  asynchronous active-low reset
- flush  input  1  exception/eret flush from CP0; kills the held instruction
- in_valid  input  1  MEM instruction valid
- in_allowin  output  1  block can accept a new instruction this cycle
- in_res_from_mem  input  1  instruction is a load
- in_res_to_mem  input  1  instruction is a store
- in_load_op  input  7  one-hot {lwr,lwl,lw,lhu,lh,lbu,lb}
- in_addr_lo  input  2  mem_addr[1:0] (unmasked)
- in_mem_ex  input  1  address exception already detected; no bus access
- in_data_wr  input  1  request write flag
- in_data_size  input  2  request size
- in_data_wstrb  input  4  request byte strobe
- in_data_addr  input  32  request address
- in_data_wdata  input  32  request write data
- in_rt_old  input  32  current rt value, used for lwl/lwr merge
- in_result  input  32  ALU result for non-load instructions
- in_dest  input  5  destination register
- data_req  output  1  SRAM-like request valid
- data_wr, data_size, data_wstrb, data_addr, data_wdata  output  1/2/4/32/32  registered request fields
- data_addr_ok  input  1  request accepted
- data_data_ok  input  1  response/write-ack returned
- data_rdata  input  32  read data
- out_valid  output  1  WB payload valid
- out_allowin  input  1  WB can accept
- out_result  output  32  final write-back value
- out_dest  output  5  destination register
- out_ex  output  1  exception flag forwarded

Behaviour:
- Reset (async, resetn=0): state IDLE, cancel=0, data_req=0, out_valid=0, all data_*/out_* registers 0.
- States:
  - IDLE: in_allowin=1. On in_valid && !flush, capture all in_* fields.
    - Memory op (load or store) with !in_mem_ex: go to REQ next cycle.
    - Otherwise: go to DONE with out_result=in_result.
  - REQ: data_req=1 and the request fields stay stable.
    - On data_addr_ok: go to WAIT.
    - Once asserted, the request is never withdrawn, flush or not.
  - WAIT: on data_data_ok, go to DONE.
    - Load: out_result = aligned(data_rdata).
    - Store: out_result = captured in_result.
  - DONE: out_valid = !cancel.
    - On out_allowin (or when cancel=1), go to IDLE.
    - in_allowin = out_allowin in DONE, so a new instruction is captured in the same cycle the old one leaves (back-to-back, no bubble).
- Latency:
  - Non-memory instruction: 1 cycle from capture to out_valid.
  - Memory instruction: 1 cycle plus addr_ok wait plus data_ok wait.
  - addr_ok and data_ok may both be high in the same cycle, but only data_ok in WAIT is honoured; data_ok arriving in REQ is ignored. At most one outstanding access.
- Flush:
  - In IDLE or DONE: drop the held instruction; out_valid=0 next cycle; state IDLE.
  - In REQ or WAIT: set cancel=1 and complete the handshake, discarding the response. In these states in_allowin=0 until the block returns to IDLE; cancel clears on entering IDLE.
  - flush has priority over in_valid capture.
- Load alignment (little-endian, b = in_addr_lo):
  - lb/lbu: byte b, sign-/zero-extended.
  - lh/lhu: half b[1], sign-/zero-extended.
  - lw: whole word.
  - lwl, b=0..3: {rdata[7:0],rt[23:0]}, {rdata[15:0],rt[15:0]}, {rdata[23:0],rt[7:0]}, rdata.
  - lwr, b=0..3: rdata, {rt[31:24],rdata[31:8]}, {rt[31:16],rdata[31:16]}, {rt[31:8],rdata[31:24]}.
- out_ex = captured in_mem_ex. With in_mem_ex=1, data_req is never asserted.
- Reset mid-access: all state clears immediately. An outstanding response after reset is the bus's responsibility (bus is reset together with the core).

Test Plan:
- ALU op, in_result=0x1234_5678, out_allowin=1 -> out_valid one cycle after capture, out_result=0x1234_5678, data_req never high.
- lb, addr_lo=3, rdata=0x80AA_BBCC, addr_ok delayed 2 cycles, data_ok delayed 3 -> data_req high exactly until addr_ok; out_result=0xFFFF_FF80.
- lwl addr_lo=1, rt_old=0x1122_3344, rdata=0xAABB_CCDD -> out_result=0xCCDD_3344. lwr addr_lo=2 with the same inputs -> 0x1122_AABB.
- sw with in_mem_ex=1 -> no data_req; out_ex=1 after 1 cycle.
- lw, flush asserted in WAIT, then data_ok=1 -> no out_valid; in_allowin returns to 1 the cycle after data_ok; the next lw completes normally.
- Back-to-back loads with out_allowin held 0 for 4 cycles -> out_valid and out_result stable; second load captured the same cycle out_allowin rises.
